// File: rtl/add_seq_if.sv
// add_seq_if: operand request and result handshake bundle for add_seq.
// The slave side is the sequencer; the master side is the surrounding
// logic that supplies operands and consumes results.
interface add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        in_cin;
  logic        in_chain;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_cout;

  modport master (
    output in_valid, in_x, in_y, in_cin, in_chain, out_ready,
    input  in_ready, out_valid, out_s, out_cout
  );

  modport slave (
    input  in_valid, in_x, in_y, in_cin, in_chain, out_ready,
    output in_ready, out_valid, out_s, out_cout
  );
endinterface

// File: rtl/add_seq.sv
// add_seq: sequencer around an external pipelined 32-bit adder.
// It launches one operand pair at a time, keeps the adder inputs frozen for
// LAT edges while the adder settles, captures sum/carry, and holds the result
// until it is consumed. A stored carry lets consecutive words form a
// multiword add (in_chain=1).
module add_seq #(
  parameter int unsigned LAT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  add_seq_if.slave    bus,
  output logic [31:0] add_x,
  output logic [31:0] add_y,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_cout,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Last count value in WAIT; the capture edge is the one that sees it.
  localparam logic [3:0] CNT_LAST = 4'(LAT - 32'd1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] add_x_r;
  logic [31:0] add_y_r;
  logic        add_cin_r;
  logic [31:0] out_s_r;
  logic        out_cout_r;
  logic        carry_r;
  logic        out_valid_r;
  logic        busy_r;

  logic        in_ready_s;
  logic        accept_s;
  logic        cin_sel_s;

  // Ready: always open when idle; in HOLD only while the held result leaves.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_HOLD: in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Accept strobe and carry-in source (stored carry for chained words).
  always_comb begin
    accept_s = bus.in_valid & in_ready_s;
    if (bus.in_chain) begin
      cin_sel_s = carry_r;
    end else begin
      cin_sel_s = bus.in_cin;
    end
  end

  // Sequencer FSM: launch operands, count adder latency, capture and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      add_x_r     <= 32'd0;
      add_y_r     <= 32'd0;
      add_cin_r   <= 1'b0;
      out_s_r     <= 32'd0;
      out_cout_r  <= 1'b0;
      carry_r     <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept_s) begin
      // Launch; in HOLD this also retires the held result (back-to-back).
      add_x_r     <= bus.in_x;
      add_y_r     <= bus.in_y;
      add_cin_r   <= cin_sel_s;
      cnt_r       <= 4'd0;
      state_r     <= ST_WAIT;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
        ST_WAIT: begin
          if (cnt_r == CNT_LAST) begin
            out_s_r     <= add_s;
            out_cout_r  <= add_cout;
            carry_r     <= add_cout;
            state_r     <= ST_HOLD;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign add_x         = add_x_r;
  assign add_y         = add_y_r;
  assign add_cin       = add_cin_r;
  assign busy          = busy_r;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_s     = out_s_r;
  assign bus.out_cout  = out_cout_r;

endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: self-checking bench for add_seq with LAT=6 and LAT=1 instances.
// The external adder is modelled as a plain 33-bit addition; the expected
// results come from a word-level model with its own stored carry.
module tb_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_seq_if bus6();
  add_seq_if bus1();

  logic [31:0] add_x6, add_y6, add_s6;
  logic        add_cin6, add_cout6, busy6;
  logic [31:0] add_x1, add_y1, add_s1;
  logic        add_cin1, add_cout1, busy1;

  assign {add_cout6, add_s6} = {1'b0, add_x6} + {1'b0, add_y6} + {32'd0, add_cin6};
  assign {add_cout1, add_s1} = {1'b0, add_x1} + {1'b0, add_y1} + {32'd0, add_cin1};

  add_seq #(.LAT(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6),
    .add_x(add_x6), .add_y(add_y6), .add_cin(add_cin6),
    .add_s(add_s6), .add_cout(add_cout6), .busy(busy6)
  );

  add_seq #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1),
    .add_s(add_s1), .add_cout(add_cout1), .busy(busy1)
  );

  logic model_carry6 = 1'b0;
  logic model_carry1 = 1'b0;

  task automatic test_reset();
    bus6.in_valid = 1'b0; bus6.in_x = 32'd0; bus6.in_y = 32'd0;
    bus6.in_cin = 1'b0; bus6.in_chain = 1'b0; bus6.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_x = 32'd0; bus1.in_y = 32'd0;
    bus1.in_cin = 1'b0; bus1.in_chain = 1'b0; bus1.out_ready = 1'b1;
    #2;
    checks++;
    if (bus6.out_valid !== 1'b0 || busy6 !== 1'b0 || bus6.in_ready !== 1'b1 ||
        add_x6 !== 32'd0 || add_y6 !== 32'd0 || add_cin6 !== 1'b0 ||
        bus6.out_s !== 32'd0 || bus6.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset6: ov=%b busy=%b rdy=%b ax=%h ay=%h ac=%b s=%h c=%b, required 0 0 1 0 0 0 0 0",
               bus6.out_valid, busy6, bus6.in_ready, add_x6, add_y6, add_cin6, bus6.out_s, bus6.out_cout);
    end
    checks++;
    if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0 || bus1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset1: ov=%b busy=%b rdy=%b, required 0 0 1", bus1.out_valid, busy1, bus1.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full operation on the LAT=6 instance, with `stall` cycles of out_ready=0.
  task automatic run_op6(input logic [31:0] x, input logic [31:0] y,
                         input logic cin, input logic chain, input int stall);
    logic [32:0] expv;
    logic        cin_eff;
    int          lat;
    cin_eff = chain ? model_carry6 : cin;
    expv = {1'b0, x} + {1'b0, y} + {32'd0, cin_eff};
    @(negedge clk);
    bus6.in_x = x; bus6.in_y = y; bus6.in_cin = cin; bus6.in_chain = chain;
    bus6.in_valid = 1'b1;
    bus6.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    checks++;
    if (add_x6 !== x || add_y6 !== y || add_cin6 !== cin_eff || busy6 !== 1'b1) begin
      errors++;
      $display("FAIL launch: ax=%h ay=%h ac=%b busy=%b, required %h %h %b 1", add_x6, add_y6, add_cin6, busy6, x, y, cin_eff);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus6.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 6", lat);
    end
    checks++;
    if (bus6.out_s !== expv[31:0] || bus6.out_cout !== expv[32]) begin
      errors++;
      $display("FAIL result: s=%h c=%b, required s=%h c=%b", bus6.out_s, bus6.out_cout, expv[31:0], expv[32]);
    end
    model_carry6 = expv[32];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus6.out_valid !== 1'b1 || bus6.out_s !== expv[31:0] || bus6.out_cout !== expv[32] || bus6.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: ov=%b s=%h c=%b rdy=%b, required 1 %h %b 0", bus6.out_valid, bus6.out_s, bus6.out_cout, bus6.in_ready, expv[31:0], expv[32]);
      end
    end
    bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus6.out_valid !== 1'b0 || busy6 !== 1'b0) begin
      errors++;
      $display("FAIL release: ov=%b busy=%b, required 0 0", bus6.out_valid, busy6);
    end
  endtask

  task automatic test_chain();
    int lat;
    @(negedge clk);
    bus6.in_x = 32'hFFFF_FFFF; bus6.in_y = 32'h0000_0001; bus6.in_cin = 1'b0;
    bus6.in_chain = 1'b0; bus6.in_valid = 1'b1; bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus6.out_valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 6 || bus6.out_s !== 32'h0000_0000 || bus6.out_cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_add: lat=%0d s=%h c=%b, required 6 00000000 1", lat, bus6.out_s, bus6.out_cout);
    end
    // chained follow-up presented while the first result is held
    bus6.in_x = 32'd0; bus6.in_y = 32'd0; bus6.in_cin = 1'b0; bus6.in_chain = 1'b1;
    bus6.in_valid = 1'b1;
    #1;
    checks++;
    if (bus6.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ready: rdy=%b, required 1", bus6.in_ready);
    end
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    checks++;
    if (add_cin6 !== 1'b1 || busy6 !== 1'b1 || bus6.out_valid !== 1'b0 || bus6.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_launch: ac=%b busy=%b ov=%b rdy=%b, required 1 1 0 0", add_cin6, busy6, bus6.out_valid, bus6.in_ready);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy6 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy: busy=%b at cycle %0d, required 1", busy6, k);
      end
      if (bus6.out_valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 6 || bus6.out_s !== 32'h0000_0001 || bus6.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL chain_add: lat=%0d s=%h c=%b, required 6 00000001 0", lat, bus6.out_s, bus6.out_cout);
    end
    model_carry6 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    run_op6(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10);
  endtask

  task automatic test_ignore();
    logic [31:0] bx, by;
    logic [32:0] expa, expb;
    int lat;
    bx = $urandom; by = $urandom;
    expa = {1'b0, 32'hF000_0000} + {1'b0, 32'hF000_0000};
    expb = {1'b0, bx} + {1'b0, by} + {32'd0, expa[32]};
    @(negedge clk);
    bus6.in_x = 32'hF000_0000; bus6.in_y = 32'hF000_0000; bus6.in_cin = 1'b0;
    bus6.in_chain = 1'b0; bus6.in_valid = 1'b1; bus6.out_ready = 1'b0;
    @(posedge clk); #1;
    bus6.in_x = bx; bus6.in_y = by; bus6.in_chain = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus6.out_valid === 1'b1) begin lat = k; break; end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 6 || add_x6 !== 32'hF000_0000 || add_y6 !== 32'hF000_0000 ||
        bus6.out_s !== expa[31:0] || bus6.out_cout !== expa[32]) begin
      errors++;
      $display("FAIL ignore_first: lat=%0d ax=%h ay=%h s=%h c=%b, required 6 f0000000 f0000000 %h %b",
               lat, add_x6, add_y6, bus6.out_s, bus6.out_cout, expa[31:0], expa[32]);
    end
    bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    checks++;
    if (add_x6 !== bx || add_y6 !== by || add_cin6 !== expa[32] || bus6.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_second: ax=%h ay=%h ac=%b ov=%b, required %h %h %b 0", add_x6, add_y6, add_cin6, bus6.out_valid, bx, by, expa[32]);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus6.out_valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 6 || bus6.out_s !== expb[31:0] || bus6.out_cout !== expb[32]) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d s=%h c=%b, required 6 %h %b", lat, bus6.out_s, bus6.out_cout, expb[31:0], expb[32]);
    end
    model_carry6 = expb[32];
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_op6(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    @(negedge clk);
    bus6.in_x = $urandom; bus6.in_y = $urandom; bus6.in_cin = 1'b1;
    bus6.in_chain = 1'b0; bus6.in_valid = 1'b1; bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus6.out_valid !== 1'b0 || busy6 !== 1'b0 || bus6.in_ready !== 1'b1 ||
        add_x6 !== 32'd0 || add_y6 !== 32'd0 || add_cin6 !== 1'b0 ||
        bus6.out_s !== 32'd0 || bus6.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b busy=%b rdy=%b ax=%h ay=%h ac=%b s=%h c=%b, required 0 0 1 0 0 0 0 0",
               bus6.out_valid, busy6, bus6.in_ready, add_x6, add_y6, add_cin6, bus6.out_s, bus6.out_cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_carry6 = 1'b0;
    model_carry1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus6.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned: out_valid=1 seen after reset, required 0");
    end
    // stored carry must have been cleared by reset
    run_op6(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_op6($urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_lat1();
    logic [31:0] x, y;
    logic        cin, chain, cin_eff;
    logic [32:0] expv;
    for (int n = 0; n < 9; n++) begin
      if (n == 0) begin
        x = 32'h8000_0000; y = 32'h8000_0000; cin = 1'b0; chain = 1'b0;
      end else begin
        x = $urandom; y = $urandom; cin = 1'($urandom_range(1, 0)); chain = 1'($urandom_range(1, 0));
      end
      cin_eff = chain ? model_carry1 : cin;
      expv = {1'b0, x} + {1'b0, y} + {32'd0, cin_eff};
      @(negedge clk);
      bus1.in_x = x; bus1.in_y = y; bus1.in_cin = cin; bus1.in_chain = chain;
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      checks++;
      if (bus1.out_valid !== 1'b0 || add_cin1 !== cin_eff) begin
        errors++;
        $display("FAIL lat1_launch: ov=%b ac=%b, required 0 %b", bus1.out_valid, add_cin1, cin_eff);
      end
      @(posedge clk); #1;
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_s !== expv[31:0] || bus1.out_cout !== expv[32]) begin
        errors++;
        $display("FAIL lat1_result: ov=%b s=%h c=%b, required 1 %h %b", bus1.out_valid, bus1.out_s, bus1.out_cout, expv[31:0], expv[32]);
      end
      model_carry1 = expv[32];
      @(posedge clk); #1;
      checks++;
      if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL lat1_release: ov=%b busy=%b, required 0 0", bus1.out_valid, busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_hold();
    test_ignore();
    test_random();
    test_lat1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_seq.md
ADD_SEQ -- requirements
Module: add_seq

Interface
REQ-001: Parameter LAT, default 6: clock edges from operand launch to result capture; legal range 1..15.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: in_valid  input  1  upstream operand request valid.
REQ-005: in_ready  output  1  block can accept an operand this cycle.
REQ-006: in_x, in_y  input  32 each  operands.
REQ-007: in_cin  input  1  carry-in, used when in_chain=0.
REQ-008: in_chain  input  1  1 = use stored carry from previous result instead of in_cin (multiword add).
REQ-009: add_x, add_y  output  32 each  registered operands driven to the pipelined adder.
REQ-010: add_cin  output  1  registered carry-in driven to the adder.
REQ-011: add_s  input  32  adder sum; add_cout  input  1  adder carry-out.
REQ-012: out_valid  output  1  result available; out_ready  input  1  downstream accepts.
REQ-013: out_s  output  32, out_cout  output  1  registered result.
REQ-014: busy  output  1  high whenever state is not IDLE.

Function
REQ-015: The block SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-016: in_ready SHALL be 1 in IDLE, 1 in HOLD when out_ready=1, else 0.
REQ-017: Accept = in_valid & in_ready; on accept edge add_x<=in_x, add_y<=in_y, add_cin<=(in_chain ? carry_q : in_cin), cnt<=0, state<=WAIT.
REQ-018: add_x, add_y, add_cin SHALL hold their value from accept until the next accept (adder inputs stable for the whole computation, since adder output bits settle at different stages).
REQ-019: In WAIT, cnt SHALL increment by 1 per edge; on the edge where cnt==LAT-1: out_s<=add_s, out_cout<=add_cout, carry_q<=add_cout, state<=HOLD.
REQ-020: Latency: out_valid SHALL rise exactly LAT cycles after the accept edge.
REQ-021: out_valid SHALL be 1 only in HOLD; out_s/out_cout SHALL be stable while out_valid=1 and out_ready=0.
REQ-022: HOLD with out_ready=1 and no accept -> IDLE; HOLD with out_ready=1 and accept -> WAIT (back-to-back, no idle cycle), chained cin uses carry_q of the result just consumed.
REQ-023: in_valid in WAIT, or in HOLD with out_ready=0, SHALL be ignored (upstream holds).
REQ-024: cnt SHALL be 4 bits, never exceed LAT-1, no wrap.
REQ-025: LAT=1: WAIT lasts one cycle; capture on first WAIT edge.
REQ-026: carry_q SHALL only update on capture; in_chain on first operation after reset uses carry_q=0.

Reset
REQ-027: rst_n low SHALL immediately force state=IDLE, cnt=0, add_x=add_y=0, add_cin=0, out_s=0, out_cout=0, carry_q=0, out_valid=0, busy=0, in_ready=1.
REQ-028: Reset asserted mid-WAIT or mid-HOLD SHALL abandon the operation with no result emitted; first post-release accept behaves as after power-up.

Verification
REQ-029: x=0xFFFFFFFF, y=0x00000001, cin=0, chain=0, out_ready=1 -> out_valid high exactly 6 cycles after accept, out_s=0x00000000, out_cout=1.
REQ-030: Follow-up x=0, y=0, chain=1 accepted back-to-back in HOLD -> add_cin=1, out_s=0x00000001, out_cout=0, no IDLE cycle between.
REQ-031: x=0x12345678, y=0x0FEDCBA9, cin=1, out_ready=0 for 10 cycles -> out_valid held, out_s=0x22222222, out_cout=0 stable, in_ready=0 until out_ready=1.
REQ-032: in_valid held high during WAIT with different operands -> add_x/add_y unchanged, second operand accepted only after first result consumed.
REQ-033: rst_n pulsed low at cnt=3 of WAIT -> all outputs zero asynchronously, out_valid never asserted for that operation, next add completes normally.
REQ-034: LAT=1 build, x=0x80000000, y=0x80000000, cin=0 -> out_valid 1 cycle after accept, out_s=0, out_cout=1.
